// File: rtl/spi_pkg.sv
// Shared types and default constants for the SPI transfer controller.
package spi_pkg;

    localparam int unsigned SPI_DATA_W     = 8;
    localparam int unsigned SPI_CLK_DIV    = 4;
    localparam int unsigned SPI_RX_TIMEOUT = 255;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        SHIFT,
        STORE,
        FAILED
    } spi_ctrl_state_t;

endpackage

// File: rtl/spi_clk_divider.sv
// Half-period tick generator: counts 0..CLK_DIV-1 while enabled, ticks on terminal count.
module spi_clk_divider #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    logic [7:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == 8'(CLK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_transfer_controller.sv
// SPI mode-0 master moving frames from a sender FIFO to a receiver FIFO,
// with back-to-back frames and a sticky timeout when the receiver stays full.
module spi_transfer_controller
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV    = SPI_CLK_DIV,
    parameter int unsigned DATA_W     = SPI_DATA_W,
    parameter int unsigned RX_TIMEOUT = SPI_RX_TIMEOUT
) (
    input  logic              S_CLK,
    input  logic              CLR,
    input  logic              ENABLE,
    input  logic              TX_EMPTY,
    input  logic [DATA_W-1:0] TX_DATA,
    output logic              TX_POP,
    input  logic              RX_FULL,
    output logic              RX_PUSH,
    output logic [DATA_W-1:0] RX_DATA,
    output logic              SCK,
    output logic              MOSI,
    input  logic              MISO,
    output logic              CS_N,
    output logic              BUSY,
    output logic              CONNECTION_FAILED
);

    localparam int unsigned BW = $clog2(DATA_W + 1);

    spi_ctrl_state_t   state_q, state_d;
    logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [7:0]        wait_q, wait_d;
    logic              sck_q, sck_d, mosi_q, mosi_d, cs_n_q, cs_n_d, fail_q, fail_d;
    logic              tick, start_ok, timed_out;

    assign start_ok  = ENABLE && !TX_EMPTY;
    assign timed_out = (wait_q == 8'(RX_TIMEOUT));

    spi_clk_divider #(.CLK_DIV(CLK_DIV)) u_div (
        .clk_i (S_CLK),
        .rst_i (CLR),
        .en_i  (state_q == SHIFT),
        .clr_i (state_q == LOAD),
        .tick_o(tick)
    );

    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        bit_d   = bit_q;
        wait_d  = wait_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        fail_d  = fail_q;
        TX_POP  = 1'b0;
        RX_PUSH = 1'b0;
        case (state_q)
            IDLE: begin
                sck_d = 1'b0;
                if (start_ok) begin
                    TX_POP  = 1'b1;
                    state_d = POP;
                end
            end
            // Read data is valid here, so capture on the POP->LOAD edge and
            // MOSI/CS_N are already settled for the whole LOAD cycle.
            POP: begin
                tx_d    = TX_DATA;
                mosi_d  = TX_DATA[DATA_W-1];
                state_d = LOAD;
            end
            LOAD: begin
                bit_d   = '0;
                wait_d  = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (tick) begin
                    if (!sck_q) begin
                        sck_d = 1'b1;
                        rx_d  = DATA_W'({rx_q, MISO});
                    end else begin
                        sck_d  = 1'b0;
                        tx_d   = tx_q << 1;
                        mosi_d = tx_d[DATA_W-1];
                        if (bit_q != BW'(DATA_W)) bit_d = bit_q + BW'(1);
                        if (bit_q == BW'(DATA_W - 1)) state_d = STORE;
                    end
                end
            end
            STORE: begin
                sck_d = 1'b0;
                // Timeout wins even if RX_FULL drops on the same cycle.
                if (timed_out) begin
                    state_d = FAILED;
                    fail_d  = 1'b1;
                    rx_d    = '0;
                end else if (!RX_FULL) begin
                    RX_PUSH = 1'b1;
                    if (start_ok) begin
                        TX_POP  = 1'b1;
                        state_d = POP;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (wait_q != 8'hFF) begin
                    wait_d = wait_q + 8'd1;
                end
            end
            FAILED:  sck_d = 1'b0;
            default: state_d = IDLE;
        endcase
        if (CLR) begin
            TX_POP  = 1'b0;
            RX_PUSH = 1'b0;
        end
    end

    // CS_N follows the next state; POP keeps it so back-to-back frames stay selected.
    always_comb begin
        case (state_d)
            LOAD, SHIFT, STORE: cs_n_d = 1'b0;
            POP:                cs_n_d = cs_n_q;
            default:            cs_n_d = 1'b1;
        endcase
    end

    always_ff @(posedge S_CLK) begin
        if (CLR) begin
            state_q <= IDLE;
            tx_q    <= '0;
            rx_q    <= '0;
            bit_q   <= '0;
            wait_q  <= '0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            bit_q   <= bit_d;
            wait_q  <= wait_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            cs_n_q  <= cs_n_d;
            fail_q  <= fail_d;
        end
    end

    assign SCK               = sck_q;
    assign MOSI              = mosi_q;
    assign CS_N              = cs_n_q;
    assign RX_DATA           = rx_q;
    assign BUSY              = (state_q != IDLE);
    assign CONNECTION_FAILED = fail_q;

endmodule

// File: tb/tb_spi_transfer_controller.sv
// Directed bench: loopback DUT (RX_TIMEOUT=255) and a timeout DUT (RX_TIMEOUT=16), both CLK_DIV=2.
module tb_spi_transfer_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clr, enable, tx_empty, tx_pop, rx_full, rx_push, sck, mosi, miso, cs_n, busy, cf;
    logic [7:0] tx_data, rx_data;
    logic       clr2, enable2, tx_pop2, rx_full2, rx_push2, sck2, mosi2, cs_n2, busy2, cf2;
    logic [7:0] rx_data2;

    assign miso = mosi;

    spi_transfer_controller #(.CLK_DIV(2), .DATA_W(8), .RX_TIMEOUT(255)) dut (
        .S_CLK(clk), .CLR(clr), .ENABLE(enable), .TX_EMPTY(tx_empty), .TX_DATA(tx_data),
        .TX_POP(tx_pop), .RX_FULL(rx_full), .RX_PUSH(rx_push), .RX_DATA(rx_data),
        .SCK(sck), .MOSI(mosi), .MISO(miso), .CS_N(cs_n), .BUSY(busy),
        .CONNECTION_FAILED(cf)
    );

    spi_transfer_controller #(.CLK_DIV(2), .DATA_W(8), .RX_TIMEOUT(16)) dut_to (
        .S_CLK(clk), .CLR(clr2), .ENABLE(enable2), .TX_EMPTY(1'b0), .TX_DATA(8'h3C),
        .TX_POP(tx_pop2), .RX_FULL(rx_full2), .RX_PUSH(rx_push2), .RX_DATA(rx_data2),
        .SCK(sck2), .MOSI(mosi2), .MISO(mosi2), .CS_N(cs_n2), .BUSY(busy2),
        .CONNECTION_FAILED(cf2)
    );

    int checks = 0, errors = 0;
    int cyc = 0;
    int n_pop, n_push, n_sck, n_cs_low, n_busy, viol, first_pop, last_push;
    int n_pop2, n_push2, first_pop2, cf2_cyc;
    logic [7:0] fifo[$];
    logic [7:0] rx_log[$];

    task automatic clear_stats();
        n_pop = 0; n_push = 0; n_sck = 0; n_cs_low = 0; n_busy = 0; viol = 0;
        first_pop = -1; last_push = -1;
        n_pop2 = 0; n_push2 = 0; first_pop2 = -1; cf2_cyc = -1;
        rx_log.delete();
    endtask

    // One clock cycle: sample at the falling edge, then model the sender FIFO after the rising edge.
    task automatic step();
        logic s_pop;
        #4;
        s_pop = tx_pop;
        if (tx_pop) begin
            n_pop++;
            if (first_pop < 0) first_pop = cyc;
            if (tx_empty) viol++;
        end
        if (rx_push) begin
            n_push++;
            last_push = cyc;
            rx_log.push_back(rx_data);
            if (rx_full) viol++;
        end
        if (sck) n_sck++;
        if (!cs_n) n_cs_low++;
        if (busy) n_busy++;
        if (tx_pop2) begin
            n_pop2++;
            if (first_pop2 < 0) first_pop2 = cyc;
        end
        if (rx_push2) n_push2++;
        if (cf2 && cf2_cyc < 0) cf2_cyc = cyc;
        @(posedge clk);
        #1;
        if (s_pop && fifo.size() > 0) tx_data = fifo.pop_front();
        tx_empty = (fifo.size() == 0);
        cyc++;
    endtask

    function automatic logic [7:0] rx_at(int i);
        return (rx_log.size() > i) ? rx_log[i] : 8'hxx;
    endfunction

    task automatic test_reset();
        clr = 1'b1; clr2 = 1'b1;
        step(); step();
        checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b expected 1", cs_n); end
        checks++; if (sck !== 1'b0) begin errors++; $display("FAIL reset_sck: got %b expected 0", sck); end
        checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b expected 0", mosi); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (cf !== 1'b0) begin errors++; $display("FAIL reset_cf: got %b expected 0", cf); end
        checks++; if (rx_push !== 1'b0) begin errors++; $display("FAIL reset_rx_push: got %b expected 0", rx_push); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
        checks++; if (cs_n2 !== 1'b1 || cf2 !== 1'b0) begin errors++; $display("FAIL reset_dut2: got cs_n=%b cf=%b expected 1 0", cs_n2, cf2); end
        clr = 1'b0; clr2 = 1'b0;
    endtask

    task automatic test_loopback();
        clear_stats();
        fifo.push_back(8'hA5); tx_empty = 1'b0; enable = 1'b1;
        repeat (50) step();
        enable = 1'b0;
        checks++; if (n_pop !== 1) begin errors++; $display("FAIL loop_pops: got %0d expected 1", n_pop); end
        checks++; if (n_push !== 1) begin errors++; $display("FAIL loop_pushes: got %0d expected 1", n_push); end
        checks++; if (rx_at(0) !== 8'hA5) begin errors++; $display("FAIL loop_rx_data: got %h expected a5", rx_at(0)); end
        checks++; if (last_push - first_pop !== 35) begin errors++; $display("FAIL loop_latency: got %0d expected 35", last_push - first_pop); end
        checks++; if (n_sck !== 16) begin errors++; $display("FAIL loop_sck_high: got %0d expected 16", n_sck); end
        checks++; if (n_cs_low !== 34) begin errors++; $display("FAIL loop_cs_low: got %0d expected 34", n_cs_low); end
        checks++; if (cs_n !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL loop_end_idle: got cs_n=%b busy=%b expected 1 0", cs_n, busy); end
        checks++; if (viol !== 0) begin errors++; $display("FAIL loop_strobe_rules: got %0d expected 0", viol); end
    endtask

    task automatic test_back_to_back();
        clear_stats();
        fifo.push_back(8'h01); fifo.push_back(8'h80); fifo.push_back(8'hFF);
        tx_empty = 1'b0; enable = 1'b1;
        repeat (130) step();
        enable = 1'b0;
        checks++; if (n_pop !== 3 || n_push !== 3) begin errors++; $display("FAIL b2b_counts: got pops=%0d pushes=%0d expected 3 3", n_pop, n_push); end
        checks++; if (rx_at(0) !== 8'h01) begin errors++; $display("FAIL b2b_rx0: got %h expected 01", rx_at(0)); end
        checks++; if (rx_at(1) !== 8'h80) begin errors++; $display("FAIL b2b_rx1: got %h expected 80", rx_at(1)); end
        checks++; if (rx_at(2) !== 8'hFF) begin errors++; $display("FAIL b2b_rx2: got %h expected ff", rx_at(2)); end
        checks++; if (last_push - first_pop !== 105) begin errors++; $display("FAIL b2b_span: got %0d expected 105", last_push - first_pop); end
        checks++; if (n_cs_low !== 104) begin errors++; $display("FAIL b2b_cs_low: got %0d expected 104", n_cs_low); end
        checks++; if (n_busy !== 105) begin errors++; $display("FAIL b2b_busy: got %0d expected 105", n_busy); end
        checks++; if (viol !== 0) begin errors++; $display("FAIL b2b_strobe_rules: got %0d expected 0", viol); end
    endtask

    task automatic test_rx_full_wait();
        clear_stats();
        fifo.push_back(8'h3C); tx_empty = 1'b0; enable = 1'b1; rx_full = 1'b1;
        for (int i = 0; i < 70; i++) begin
            if (first_pop >= 0 && cyc >= first_pop + 45) rx_full = 1'b0;
            step();
        end
        enable = 1'b0; rx_full = 1'b0;
        checks++; if (n_push !== 1) begin errors++; $display("FAIL wait_pushes: got %0d expected 1", n_push); end
        checks++; if (last_push - first_pop !== 45) begin errors++; $display("FAIL wait_push_cycle: got %0d expected 45", last_push - first_pop); end
        checks++; if (rx_at(0) !== 8'h3C) begin errors++; $display("FAIL wait_rx_data: got %h expected 3c", rx_at(0)); end
        checks++; if (cf !== 1'b0) begin errors++; $display("FAIL wait_cf: got %b expected 0", cf); end
        checks++; if (viol !== 0) begin errors++; $display("FAIL wait_strobe_rules: got %0d expected 0", viol); end
    endtask

    task automatic test_timeout();
        clear_stats();
        enable2 = 1'b1; rx_full2 = 1'b1;
        repeat (80) step();
        checks++; if (n_pop2 !== 1 || n_push2 !== 0) begin errors++; $display("FAIL to_strobes: got pops=%0d pushes=%0d expected 1 0", n_pop2, n_push2); end
        checks++; if (cf2_cyc - first_pop2 !== 52) begin errors++; $display("FAIL to_fail_cycle: got %0d expected 52", cf2_cyc - first_pop2); end
        checks++; if (cf2 !== 1'b1 || cs_n2 !== 1'b1 || sck2 !== 1'b0) begin errors++; $display("FAIL to_failed_outputs: got cf=%b cs_n=%b sck=%b expected 1 1 0", cf2, cs_n2, sck2); end
        checks++; if (busy2 !== 1'b1 || rx_data2 !== 8'h00) begin errors++; $display("FAIL to_failed_state: got busy=%b rx=%h expected 1 00", busy2, rx_data2); end
        rx_full2 = 1'b0;
        repeat (20) step();
        checks++; if (n_pop2 !== 1 || cf2 !== 1'b1) begin errors++; $display("FAIL to_sticky: got pops=%0d cf=%b expected 1 1", n_pop2, cf2); end
        clr2 = 1'b1;
        step();
        clr2 = 1'b0; enable2 = 1'b0;
        checks++; if (cf2 !== 1'b0 || busy2 !== 1'b0) begin errors++; $display("FAIL to_clr: got cf=%b busy=%b expected 0 0", cf2, busy2); end
    endtask

    task automatic test_clr_mid_frame();
        clear_stats();
        fifo.push_back(8'h5A); tx_empty = 1'b0; enable = 1'b1;
        step();
        enable = 1'b0;
        repeat (19) step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        checks++; if (cs_n !== 1'b1 || sck !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL clr_outputs: got cs_n=%b sck=%b busy=%b expected 1 0 0", cs_n, sck, busy); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL clr_rx_data: got %h expected 00", rx_data); end
        repeat (45) step();
        checks++; if (n_pop !== 1 || n_push !== 0) begin errors++; $display("FAIL clr_no_push: got pops=%0d pushes=%0d expected 1 0", n_pop, n_push); end
    endtask

    task automatic test_enable_drop();
        clear_stats();
        fifo.push_back(8'h77); fifo.push_back(8'h66); tx_empty = 1'b0; enable = 1'b1;
        for (int i = 0; i < 80; i++) begin
            if (first_pop >= 0 && cyc >= first_pop + 12) enable = 1'b0;
            step();
        end
        checks++; if (n_pop !== 1 || n_push !== 1) begin errors++; $display("FAIL en_counts: got pops=%0d pushes=%0d expected 1 1", n_pop, n_push); end
        checks++; if (rx_at(0) !== 8'h77) begin errors++; $display("FAIL en_rx_data: got %h expected 77", rx_at(0)); end
        checks++; if (fifo.size() !== 1 || cs_n !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL en_idle: got fifo=%0d cs_n=%b busy=%b expected 1 1 0", fifo.size(), cs_n, busy); end
        fifo.delete(); tx_empty = 1'b1;
    endtask

    initial begin
        clr = 1'b1; clr2 = 1'b1; enable = 1'b0; enable2 = 1'b0;
        tx_empty = 1'b1; tx_data = 8'h00; rx_full = 1'b0; rx_full2 = 1'b0;
        clear_stats();
        @(posedge clk);
        #1;
        test_reset();
        test_loopback();
        test_back_to_back();
        test_rx_full_wait();
        test_timeout();
        test_clr_mid_frame();
        test_enable_drop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
